// File: rtl/booth_mult_arbiter.sv
// Round-robin front end sharing one serial-load booth_multiplier among NREQ requesters.
// Grant registered 1 cycle after req; resp_valid A_HOLD+B_HOLD+WAIT+2 cycles later; new reqs wait in IDLE.
module booth_mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int A_HOLD  = 100,
  parameter int B_HOLD  = 100,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   resp_valid,
  output logic [2*W-1:0]    result,
  output logic              resp_err,
  output logic              busy,
  output logic              mult_start,
  output logic [W-1:0]      mult_data_in,
  input  logic              mult_done,
  input  logic [2*W-1:0]    mult_ans
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (TIMEOUT > A_HOLD) ? ((TIMEOUT > B_HOLD) ? TIMEOUT : B_HOLD)
                                           : ((A_HOLD > B_HOLD) ? A_HOLD : B_HOLD);
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_LOAD_A, S_LOAD_B, S_WAIT, S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*W-1:0]    result_q, result_d;
  logic              err_q, err_d;
  logic              done_q;

  logic              sel_vld;
  logic [PW-1:0]     sel_idx;
  logic [PW-1:0]     cand;

  // Scan from the farthest offset down so the nearest request at/after ptr_q wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = PW'((int'(ptr_q) + i) % NREQ);
      if (req[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gidx_d       = gidx_q;
    grant_d      = grant_q;
    a_d          = a_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    err_d        = err_q;
    mult_start   = 1'b0;
    mult_data_in = '0;
    resp_valid   = '0;
    case (state_q)
      S_IDLE: begin
        if (sel_vld) begin
          grant_d = NREQ'(1) << sel_idx;
          gidx_d  = sel_idx;
          a_d     = op_a[int'(sel_idx)*W +: W];
          b_d     = op_b[int'(sel_idx)*W +: W];
          state_d = S_START;
        end
      end
      S_START: begin
        mult_start   = 1'b1;
        mult_data_in = a_q;
        cnt_d        = '0;
        state_d      = S_LOAD_A;
      end
      S_LOAD_A: begin
        mult_data_in = a_q;
        if (cnt_q == CW'(A_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = S_LOAD_B;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOAD_B: begin
        mult_data_in = b_q;
        if (cnt_q == CW'(B_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        mult_data_in = b_q;
        // Only a fresh rising edge counts; a done level left over from the last job is stale.
        if (mult_done && !done_q) begin
          result_d = mult_ans;
          err_d    = 1'b0;
          state_d  = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        resp_valid = grant_q;
        grant_d    = '0;
        ptr_d      = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
      done_q   <= mult_done;
    end
  end

  assign grant    = grant_q;
  assign result   = result_q;
  assign resp_err = err_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
- Round-robin scheduler that shares one booth_multiplier among NREQ requesters.
- Each requester presents a signed operand pair. The block grants one requester at a time and drives the multiplier's serial load protocol: start pulse with multiplicand, hold multiplicand, then hold multiplier.
- It waits for done, then returns the 16-bit product (or a timeout error) to the granted requester.
- Sits between client logic and the single booth_multiplier instance.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 8, operand width; product is 2*W
A_HOLD, 100, cycles mult_data_in holds multiplicand after the start cycle
B_HOLD, 100, cycles mult_data_in holds multiplier before done is monitored
TIMEOUT, 1000, max WAIT cycles for mult_done before error

Ports:
clk_100MHz  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester request level
op_a  in  NREQ*W  multiplicands, requester i at [i*W +: W], two's complement
op_b  in  NREQ*W  multipliers, same packing
grant  out  NREQ  one-hot, high from grant until the response cycle inclusive
resp_valid  out  NREQ  one-cycle pulse to the served requester
result  out  2*W  product; valid when any resp_valid bit is high, held until the next response
resp_err  out  1  qualifies resp_valid; 1 = timeout, result forced to 0
busy  out  1  high in every state except IDLE
mult_start  out  1  to booth_multiplier start
mult_data_in  out  W  to booth_multiplier data_in
mult_done  in  1  from booth_multiplier done
mult_ans  in  2*W  from booth_multiplier ans

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, RR pointer = 0, counters 0, captured operands 0. Reset asserted mid-operation aborts immediately: no response is issued and mult_start drops. The multiplier itself is not reset; the next start re-initialises it.
- States: IDLE, START, LOAD_A, LOAD_B, WAIT, RESP.
- IDLE:
  - If any req is high, select the first high bit at or after the RR pointer, wrapping modulo NREQ.
  - Next edge: register grant one-hot, latch that requester's op_a/op_b, go to START.
  - With no req, stay in IDLE.
- START (1 cycle): mult_start=1, mult_data_in=latched a. Go to LOAD_A.
- LOAD_A: mult_start=0, mult_data_in=a for exactly A_HOLD cycles, then go to LOAD_B.
- LOAD_B: mult_data_in=b for exactly B_HOLD cycles, then go to WAIT.
- WAIT:
  - mult_data_in holds b.
  - Register mult_done every cycle. Completion is a rising edge (mult_done=1 with previous sample 0) seen in WAIT. A done level left high from the previous operation is ignored.
  - On the edge: capture mult_ans into result, resp_err=0, go to RESP.
  - If TIMEOUT cycles elapse in WAIT with no edge: result=0, resp_err=1, go to RESP.
- RESP (1 cycle): resp_valid[g]=1, grant stays high this cycle. Next edge: grant=0, RR pointer=(g+1) mod NREQ, go to IDLE.
- mult_data_in is 0 in IDLE and RESP.
- Latency, grant-register edge to resp_valid: 1 + A_HOLD + B_HOLD + (WAIT cycles) + 1.
- Requester rules:
  - Operands need be stable only in the cycle the grant is registered; they are latched.
  - Dropping req before grant cancels the request silently.
  - Dropping req after grant does not abort; the response is still pulsed.
  - Holding req through resp_valid counts as a new request, but the RR pointer guarantees every other pending requester is served first.
- Simultaneous requests: exactly one grant, lowest index at or after the pointer. No starvation: the worst-case wait is NREQ-1 services.
- A new req arriving while busy is queued by level only; no state changes until IDLE.
- result is signed 2*W, copied verbatim from mult_ans; no arithmetic is done in this block.

Test Plan:
- Single requester 0, a=5, b=3, booth_multiplier attached -> grant=0001, one mult_start pulse, data_in=5 for 101 cycles then 3 for 100 cycles, resp_valid=0001 with result=15, resp_err=0.
- Signed sweep on requester 2: (-5,3), (5,-3), (-5,-3), (127,127), (-128,-128) -> results -15, -15, 15, 16129, 16384; only grant[2] and resp_valid[2] toggle.
- All four req held high from reset with distinct operands -> grants in order 0,1,2,3,0; each resp_valid bit pulses once per round with the correct product; busy stays high across the back-to-back operations except the single IDLE cycle between them.
- Multiplier model that never raises done (and one whose done stays stuck high) -> after the WAIT stage runs exactly TIMEOUT cycles, resp_err=1 and result=0; the next requester is then served normally.
- Reset asserted during LOAD_B -> all outputs 0 asynchronously, no resp_valid; after release, a pending req is granted from pointer 0 and completes correctly.
- req[1] pulsed for one cycle while requester 0 is busy -> request 1 is dropped, no grant[1]; req[1] held during busy -> granted immediately after requester 0's RESP.
